// File: rtl/gray_fifo_ptr_ctrl.sv
// Single-clock FIFO pointer controller: binary wrap-bit pointers, registered
// Gray copies, occupancy and full/empty/overflow/underflow flags.
module gray_fifo_ptr_ctrl #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wr_accept,
    output logic              rd_accept,
    output logic [ADDR_W:0]   wr_ptr_gray,
    output logic [ADDR_W:0]   rd_ptr_gray,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic [ADDR_W:0] wr_ptr_n;
    logic [ADDR_W:0] rd_ptr_n;

    assign wr_accept = wr_en & ~full;
    assign rd_accept = rd_en & ~empty;

    assign wr_ptr_n = wr_ptr + {{ADDR_W{1'b0}}, wr_accept};
    assign rd_ptr_n = rd_ptr + {{ADDR_W{1'b0}}, rd_accept};

    assign wr_addr = wr_ptr[ADDR_W-1:0];
    assign rd_addr = rd_ptr[ADDR_W-1:0];

    // Flags and Gray copies are derived from the next pointers so they line up
    // with the binary pointers in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            wr_ptr_gray <= '0;
            rd_ptr_gray <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            count       <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr_n;
            rd_ptr      <= rd_ptr_n;
            wr_ptr_gray <= wr_ptr_n ^ (wr_ptr_n >> 1);
            rd_ptr_gray <= rd_ptr_n ^ (rd_ptr_n >> 1);
            full        <= (wr_ptr_n[ADDR_W] != rd_ptr_n[ADDR_W]) &&
                           (wr_ptr_n[ADDR_W-1:0] == rd_ptr_n[ADDR_W-1:0]);
            empty       <= (wr_ptr_n == rd_ptr_n);
            count       <= wr_ptr_n - rd_ptr_n;
            overflow    <= wr_en & full;
            underflow   <= rd_en & empty;
        end
    end

endmodule
